// File: rtl/count_pkg.sv
// count_cmd_driver shared types: command opcodes, FSM states
// and default widths for the counter and error counter.
package count_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int ERRW_DEF  = 8;

   typedef enum logic [1:0] {
      OP_CRST = 2'b00,
      OP_LOAD = 2'b01,
      OP_UP   = 2'b10,
      OP_DOWN = 2'b11
   } cmd_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CRST = 2'b01,
      S_LOAD = 2'b10,
      S_RUN  = 2'b11
   } state_e;

endpackage

// File: rtl/count_cmd_driver_if.sv
// Command handshake bundle for count_cmd_driver.
// master: drives valid/op/data; slave: drives ready.
interface count_cmd_driver_if #(
   parameter int WIDTH = 4
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_data,
      output cmd_ready
   );

endinterface

// File: rtl/count_ref_model.sv
// Mirror of the external up/down counter, fed from the driver's
// registered outputs. Ports: clock/reset, i_cnt_* controls, o_exp value.
module count_ref_model
   import count_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_cnt_rst,
   input  logic             i_cnt_load,
   input  logic             i_cnt_ud,
   input  logic [WIDTH-1:0] i_cnt_din,
   output logic [WIDTH-1:0] o_exp,
   output logic             o_exp_valid
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_exp;
   logic             r_exp_valid;

   // Same priority as the counter: reset, load, then step.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_exp       <= '0;
         r_exp_valid <= 1'b0;
      end else begin
         if (i_cnt_rst) begin
            r_exp <= '0;
         end else if (i_cnt_load) begin
            r_exp <= i_cnt_din;
         end else if (i_cnt_ud) begin
            r_exp <= r_exp + ONE;
         end else begin
            r_exp <= r_exp - ONE;
         end
         // Counter value is unknown until first forced to a value.
         if (i_cnt_rst || i_cnt_load) begin
            r_exp_valid <= 1'b1;
         end
      end
   end

   assign o_exp       = r_exp;
   assign o_exp_valid = r_exp_valid;

endmodule

// File: rtl/count_cmd_driver.sv
// Command-driven controller for an external up/down counter with
// read-back checking. Ports: clock/reset, cmd (slave handshake),
// cnt_* counter controls, count read-back, cmd_done, err, err_cnt.
module count_cmd_driver
   import count_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int ERRW  = ERRW_DEF
) (
   input  logic              clock,
   input  logic              reset,
   count_cmd_driver_if.slave cmd,
   output logic              cnt_rst,
   output logic [WIDTH-1:0]  cnt_din,
   output logic              cnt_load,
   output logic              cnt_ud,
   input  logic [WIDTH-1:0]  count,
   output logic              cmd_done,
   output logic              err,
   output logic [ERRW-1:0]   err_cnt
);

   localparam logic [WIDTH:0] ONE_L =
      {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH:0] FULL =
      {1'b1, {WIDTH{1'b0}}};
   localparam logic [ERRW-1:0] ONE_E =
      {{(ERRW-1){1'b0}}, 1'b1};

   state_e           r_state;
   state_e           w_state_nxt;
   logic [WIDTH:0]   r_left;
   logic [WIDTH:0]   w_left_nxt;
   logic             r_cnt_rst;
   logic             w_rst_nxt;
   logic             r_cnt_load;
   logic             w_load_nxt;
   logic [WIDTH-1:0] r_cnt_din;
   logic [WIDTH-1:0] w_din_nxt;
   logic             r_cnt_ud;
   logic             w_ud_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             r_err;
   logic [ERRW-1:0]  r_err_cnt;

   logic             w_ready;
   logic             w_accept;
   cmd_op_e          w_op;
   logic [WIDTH-1:0] w_exp;
   logic             w_exp_valid;
   logic             w_mm;

   assign w_ready  = (r_state == S_IDLE) && reset;
   assign w_accept = cmd.cmd_valid && w_ready;
   assign w_op     = cmd_op_e'(cmd.cmd_op);

   assign cmd.cmd_ready = w_ready;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_left     <= '0;
         r_cnt_rst  <= 1'b0;
         r_cnt_load <= 1'b0;
         r_cnt_din  <= '0;
         r_cnt_ud   <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_left     <= w_left_nxt;
         r_cnt_rst  <= w_rst_nxt;
         r_cnt_load <= w_load_nxt;
         r_cnt_din  <= w_din_nxt;
         r_cnt_ud   <= w_ud_nxt;
         r_done     <= w_done_nxt;
      end
   end

   // Outputs are computed one cycle ahead so that the registered
   // values line up with the state they belong to.
   always_comb begin
      w_state_nxt = r_state;
      w_left_nxt  = r_left;
      w_rst_nxt   = 1'b0;
      w_load_nxt  = 1'b0;
      w_din_nxt   = '0;
      w_ud_nxt    = r_cnt_ud;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               unique case (w_op)
                  OP_CRST: begin
                     w_state_nxt = S_CRST;
                     w_rst_nxt   = 1'b1;
                  end
                  OP_LOAD: begin
                     w_state_nxt = S_LOAD;
                     w_load_nxt  = 1'b1;
                     w_din_nxt   = cmd.cmd_data;
                  end
                  OP_UP, OP_DOWN: begin
                     w_state_nxt = S_RUN;
                     w_ud_nxt    = (w_op == OP_UP);
                     // A step count of zero means a full lap.
                     if (cmd.cmd_data == '0) begin
                        w_left_nxt = FULL;
                     end else begin
                        w_left_nxt = {1'b0, cmd.cmd_data};
                     end
                  end
               endcase
            end
         end
         S_CRST, S_LOAD: begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
         end
         S_RUN: begin
            w_left_nxt = r_left - ONE_L;
            if (r_left == ONE_L) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
      endcase
   end

   count_ref_model #(
      .WIDTH (WIDTH)
   ) u_ref (
      .clock       (clock),
      .reset       (reset),
      .i_cnt_rst   (r_cnt_rst),
      .i_cnt_load  (r_cnt_load),
      .i_cnt_ud    (r_cnt_ud),
      .i_cnt_din   (r_cnt_din),
      .o_exp       (w_exp),
      .o_exp_valid (w_exp_valid)
   );

   assign w_mm = w_exp_valid && (count != w_exp);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else if (w_mm) begin
         r_err <= 1'b1;
         if (r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + ONE_E;
         end
      end
   end

   assign cnt_rst  = r_cnt_rst;
   assign cnt_load = r_cnt_load;
   assign cnt_din  = r_cnt_din;
   assign cnt_ud   = r_cnt_ud;
   assign cmd_done = r_done;
   assign err      = r_err;
   assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_count_cmd_driver.sv
// Directed bench for count_cmd_driver with an external counter
// model driving the count read-back.
module tb_count_cmd_driver;
   import count_pkg::*;

   localparam int W = 4;
   localparam int E = 8;

   logic         clock;
   logic         reset;
   logic         cnt_rst;
   logic         cnt_load;
   logic         cnt_ud;
   logic         cmd_done;
   logic         err;
   logic [W-1:0] cnt_din;
   logic [W-1:0] count;
   logic [E-1:0] err_cnt;
   logic [W-1:0] tb_cnt;
   logic         force_mm;

   int n_chk;
   int n_fail;
   int n_done;
   int n_load;

   count_cmd_driver_if #(.WIDTH(W)) cmd_if ();

   count_cmd_driver #(
      .WIDTH (W),
      .ERRW  (E)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .cmd      (cmd_if),
      .cnt_rst  (cnt_rst),
      .cnt_din  (cnt_din),
      .cnt_load (cnt_load),
      .cnt_ud   (cnt_ud),
      .count    (count),
      .cmd_done (cmd_done),
      .err      (err),
      .err_cnt  (err_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (cnt_rst) tb_cnt <= '0;
      else if (cnt_load) tb_cnt <= cnt_din;
      else if (cnt_ud) tb_cnt <= tb_cnt + 4'd1;
      else tb_cnt <= tb_cnt - 4'd1;
   end

   assign count = force_mm ? (tb_cnt ^ 4'h1) : tb_cnt;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d",
                  tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      if (cmd_done) n_done++;
      if (cnt_load) n_load++;
   endtask

   task automatic send(input cmd_op_e op,
                       input logic [W-1:0] d);
      logic acc;
      int   k;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_data  = d;
      acc = 1'b0;
      k   = 0;
      while (!acc && k < 40) begin
         acc = cmd_if.cmd_ready;
         tick();
         k++;
      end
      cmd_if.cmd_valid = 1'b0;
      chk("accepted", {31'd0, acc}, 32'd1);
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!cmd_done && cyc < 64);
      chk("done_seen", {31'd0, cmd_done}, 32'd1);
   endtask

   int cyc;
   int n0;
   logic [3:0] up3 [0:3];
   logic [3:0] up4 [0:3];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      n_chk = 0;
      n_fail = 0;
      n_done = 0;
      n_load = 0;
      force_mm = 1'b0;
      up3 = '{4'd5, 4'd6, 4'd7, 4'd8};
      up4 = '{4'd15, 4'd0, 4'd1, 4'd2};
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 2'b00;
      cmd_if.cmd_data  = '0;
      reset = 1'b0;
      repeat (3) tick();

      chk("rst_cnt_rst", cnt_rst, 0);
      chk("rst_cnt_load", cnt_load, 0);
      chk("rst_cnt_din", cnt_din, 0);
      chk("rst_cnt_ud", cnt_ud, 1);
      chk("rst_done", cmd_done, 0);
      chk("rst_err", err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_ready", cmd_if.cmd_ready, 0);
      chk("rst_exp_valid", dut.w_exp_valid, 0);
      chk("rst_exp", dut.w_exp, 0);
      reset = 1'b1;
      #1;
      chk("idle_ready", cmd_if.cmd_ready, 1);

      // CRST, LOAD 5, UP 3
      send(OP_CRST, 4'd0);
      chk("crst_pulse", cnt_rst, 1);
      wait_done(cyc);
      chk("crst_len", cyc, 1);
      chk("crst_cnt", count, 0);
      chk("crst_expv", dut.w_exp_valid, 1);
      n0 = n_done;
      send(OP_LOAD, 4'd5);
      chk("ld5_strobe", cnt_load, 1);
      chk("ld5_din", cnt_din, 5);
      wait_done(cyc);
      chk("ld5_cnt0", count, up3[0]);
      chk("ld5_exp0", dut.w_exp, up3[0]);
      send(OP_UP, 4'd3);
      chk("up3_ud", cnt_ud, 1);
      for (int i = 1; i < 4; i++) begin
         if (i > 1) tick();
         chk("up3_cnt", count, up3[i]);
         chk("up3_exp", dut.w_exp, up3[i]);
      end
      wait_done(cyc);
      chk("up3_dones", n_done - n0, 2);
      chk("up3_err", err, 0);

      // LOAD 14, UP 4 with wrap
      send(OP_LOAD, 4'd14);
      wait_done(cyc);
      chk("ld14_cnt", count, 14);
      send(OP_UP, 4'd4);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         chk("up4_cnt", count, up4[i]);
      end
      wait_done(cyc);
      chk("wrap_err", err, 0);
      chk("wrap_err_cnt", err_cnt, 0);

      // LOAD 1, DOWN 0 -> full lap of 16
      send(OP_LOAD, 4'd1);
      wait_done(cyc);
      chk("ld1_cnt", count, 1);
      n0 = n_done;
      send(OP_DOWN, 4'd0);
      chk("dn_ud", cnt_ud, 0);
      chk("dn_cnt0", count, 2);
      wait_done(cyc);
      chk("dn_len", cyc, 16);
      chk("dn_done_cnt", count, 2);
      tick();
      chk("dn_after_cnt", count, 1);
      chk("dn_done_low", cmd_done, 0);
      chk("dn_dones", n_done - n0, 1);
      chk("dn_err", err, 0);

      // Forced mismatches
      force_mm = 1'b1;
      repeat (3) tick();
      force_mm = 1'b0;
      chk("mm3_err", err, 1);
      chk("mm3_cnt", err_cnt, 3);
      tick();
      chk("mm3_hold", err_cnt, 3);
      chk("mm3_sticky", err, 1);
      force_mm = 1'b1;
      repeat (300) tick();
      force_mm = 1'b0;
      chk("mm_sat", err_cnt, 255);
      tick();
      chk("mm_sat_hold", err_cnt, 255);

      // Reset during RUN
      send(OP_UP, 4'd5);
      n0 = n_done;
      reset = 1'b0;
      #1;
      chk("rr_ready_low", cmd_if.cmd_ready, 0);
      tick();
      reset = 1'b1;
      chk("rr_cnt_rst", cnt_rst, 0);
      chk("rr_cnt_load", cnt_load, 0);
      chk("rr_cnt_din", cnt_din, 0);
      chk("rr_cnt_ud", cnt_ud, 1);
      chk("rr_done", cmd_done, 0);
      chk("rr_err", err, 0);
      chk("rr_err_cnt", err_cnt, 0);
      chk("rr_expv", dut.w_exp_valid, 0);
      #1;
      chk("rr_ready", cmd_if.cmd_ready, 1);
      repeat (8) tick();
      chk("rr_no_done", n_done - n0, 0);
      chk("rr_no_err", err, 0);

      // cmd_valid held while busy
      send(OP_LOAD, 4'd7);
      chk("busy_ready", cmd_if.cmd_ready, 0);
      n0 = n_load;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = OP_LOAD;
      cmd_if.cmd_data  = 4'd9;
      tick();
      chk("busy_cnt7", count, 7);
      chk("busy_idle_rdy", cmd_if.cmd_ready, 1);
      tick();
      cmd_if.cmd_valid = 1'b0;
      chk("busy_ld9", cnt_load, 1);
      chk("busy_din9", cnt_din, 9);
      tick();
      chk("busy_cnt9", count, 9);
      repeat (4) tick();
      chk("busy_once", n_load - n0, 1);
      chk("busy_cnt13", count, 13);
      chk("busy_exp13", dut.w_exp, 13);
      chk("busy_err", err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
